// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and default baud divisor.
// Also intended for the receive side.
package uart_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // 12 MHz / 115200 baud
    localparam int DEF_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } uart_state_t;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by the UART transmitter.
// The master side issues re; the slave (FIFO) side returns empty and q.
interface fifo_uart_tx_if #(parameter int DATA_WIDTH = 8) ();
    logic                  empty;
    logic [DATA_WIDTH-1:0] q;
    logic                  re;

    modport master (output re, input empty, input q);
    modport slave  (input re, output empty, output q);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: down-counter that reloads on load or when it reaches zero.
// tick marks the last cycle of each bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load || cnt == '0)
            cnt <= RELOAD;
        else
            cnt <= cnt - 1'b1;
    end

    assign tick = (cnt == '0);
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-read FIFO into an 8N1-style UART line, LSB first.
// One re pulse per frame; the word is captured the cycle after re.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_uart_tx_if.master  fifo,
    output logic            tx,
    output logic            busy
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_t           state, state_d;
    logic [DATA_WIDTH-1:0] sreg, sreg_d;
    logic [BW-1:0]         bit_idx, bit_idx_d;
    logic                  tx_d;
    logic                  load;
    logic                  tick;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            bit_idx <= '0;
            sreg    <= '0;
        end else begin
            state   <= state_d;
            tx      <= tx_d;
            busy    <= (state_d != IDLE);
            bit_idx <= bit_idx_d;
            sreg    <= sreg_d;
        end
    end

    always_comb begin
        state_d   = state;
        sreg_d    = sreg;
        bit_idx_d = bit_idx;
        tx_d      = tx;
        load      = 1'b0;
        fifo.re   = 1'b0;
        unique case (state)
            IDLE: begin
                // re is gated by rst_n so it is low for the whole reset pulse
                if (rst_n && !fifo.empty) begin
                    fifo.re = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                sreg_d    = fifo.q;
                bit_idx_d = '0;
                tx_d      = 1'b0;
                load      = 1'b1;
                state_d   = START;
            end
            START: begin
                if (tick) begin
                    tx_d    = sreg[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        tx_d      = 1'b1;
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        sreg_d    = sreg >> 1;
                        tx_d      = sreg_d[0];
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                // bit_idx is reused to count stop-bit periods
                if (tick) begin
                    if (bit_idx == LAST_STOP)
                        state_d = IDLE;
                    else
                        bit_idx_d = bit_idx + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: an 8-bit/C=4 instance and a 2-bit/C=2/2-stop instance.
module tb_fifo_uart_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx8, busy8, tx2, busy2;
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   t1, t2;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) f8 ();
    fifo_uart_tx_if #(.DATA_WIDTH(2)) f2 ();

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .fifo(f8), .tx(tx8), .busy(busy8));
    fifo_uart_tx #(.DATA_WIDTH(2), .CLKS_PER_BIT(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .fifo(f2), .tx(tx2), .busy(busy2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit e, input logic [15:0] d);
        if (sel) begin
            f2.empty = e;
            f2.q     = d[1:0];
        end else begin
            f8.empty = e;
            f8.q     = d[7:0];
        end
    endtask

    // Entered at the negedge of the re cycle T; q must already hold the word.
    // Checks cycles T+1 .. last stop cycle and leaves empty/q set for IDLE re-entry.
    task automatic run_frame(input string tag, input bit sel, input logic [15:0] data,
                             input int dw, input int c, input int sb,
                             input bit hold_empty, input bit noise,
                             input bit last_empty, input logic [15:0] next_q);
        int n_tot;
        int b;
        bit emp;
        logic otx, obusy, ore, etx;
        n_tot = (dw + 1 + sb) * c + 1;
        emp = hold_empty;
        @(posedge clk); #1;
        if (sel) f2.empty = emp; else f8.empty = emp;
        for (int n = 1; n <= n_tot; n++) begin
            @(negedge clk);
            otx   = sel ? tx2 : tx8;
            obusy = sel ? busy2 : busy8;
            ore   = sel ? f2.re : f8.re;
            b = (n - 2) / c;
            if (n == 1)       etx = 1'b1;
            else if (b == 0)  etx = 1'b0;
            else if (b <= dw) etx = data[b-1];
            else              etx = 1'b1;
            chk($sformatf("%s_tx%0d", tag, n), otx, etx);
            chk($sformatf("%s_busy%0d", tag, n), obusy, 1);
            chk($sformatf("%s_re%0d", tag, n), ore, 0);
            if (n == n_tot)
                drive(sel, last_empty, next_q);
            else if (noise && n >= 2) begin
                emp = ~emp;
                drive(sel, emp, 16'($urandom));
            end
        end
    endtask

    initial begin
        f8.empty = 1'b0;
        f8.q     = 8'hA5;
        f2.empty = 1'b1;
        f2.q     = 2'b00;

        // reset holds re low even with data available
        repeat (10) begin
            @(negedge clk);
            chk("rst_re", f8.re, 0);
            chk("rst_tx", tx8, 1);
            chk("rst_busy", busy8, 0);
            chk("rst_re2", f2.re, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_re", f8.re, 1);

        // single word A5
        run_frame("a5", 1'b0, 16'hA5, 8, 4, 1, 1'b1, 1'b0, 1'b1, 16'h00);
        @(negedge clk);
        chk("a5_end_re", f8.re, 0);
        chk("a5_end_busy", busy8, 0);
        chk("a5_end_tx", tx8, 1);

        // back-to-back 00 then FF
        @(posedge clk); #1;
        f8.empty = 1'b0;
        f8.q     = 8'h00;
        @(negedge clk);
        chk("b2b_re1", f8.re, 1);
        t1 = cyc;
        run_frame("b00", 1'b0, 16'h00, 8, 4, 1, 1'b0, 1'b0, 1'b0, 16'hFF);
        @(negedge clk);
        chk("b2b_re2", f8.re, 1);
        chk("b2b_gap_tx", tx8, 1);
        chk("b2b_gap_busy", busy8, 0);
        t2 = cyc;
        chk("b2b_re_spacing", t2 - t1, 42);
        run_frame("bff", 1'b0, 16'hFF, 8, 4, 1, 1'b0, 1'b0, 1'b1, 16'h00);
        repeat (3) begin
            @(negedge clk);
            chk("b2b_after_re", f8.re, 0);
            chk("b2b_after_busy", busy8, 0);
        end

        // narrow config, q=2'b10
        @(posedge clk); #1;
        f2.empty = 1'b0;
        f2.q     = 2'b10;
        @(negedge clk);
        chk("nar_re", f2.re, 1);
        run_frame("nar", 1'b1, 16'h2, 2, 2, 2, 1'b1, 1'b0, 1'b1, 16'h0);
        @(negedge clk);
        chk("nar_end_busy", busy2, 0);
        chk("nar_end_tx", tx2, 1);
        chk("nar_end_re", f2.re, 0);

        // input noise during the frame
        @(posedge clk); #1;
        f8.empty = 1'b0;
        f8.q     = 8'h3C;
        @(negedge clk);
        chk("noise_re", f8.re, 1);
        run_frame("n3c", 1'b0, 16'h3C, 8, 4, 1, 1'b1, 1'b1, 1'b1, 16'h00);
        @(negedge clk);
        chk("noise_end_re", f8.re, 0);
        chk("noise_end_busy", busy8, 0);

        // reset mid-DATA (A5 bit 1 is low at T+11)
        @(posedge clk); #1;
        f8.empty = 1'b0;
        f8.q     = 8'hA5;
        @(negedge clk);
        chk("mid_re", f8.re, 1);
        @(posedge clk); #1 f8.empty = 1'b1;
        repeat (11) @(negedge clk);
        chk("mid_pre_tx", tx8, 0);
        chk("mid_pre_busy", busy8, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_tx", tx8, 1);
        chk("mid_async_busy", busy8, 0);
        chk("mid_async_re", f8.re, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("mid_post_tx", tx8, 1);
            chk("mid_post_re", f8.re, 0);
            chk("mid_post_busy", busy8, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
